rom_download_loader: RTL and testbench

Sits between the `hps_io` ioctl download stream and the `williams2` ROM write port. It converts the byte-serial ROM download into handshaked writes. Each write is routed to one of three ROM regions (program, sound, graphics) with a region-local address. The block also holds the game core in reset until a complete, error-free image has been loaded, plus a fixed settle time after that.

---
 rtl/rom_download_loader.sv | 159 +++++++++++++++
 tb/tb_rom_download_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_download_loader.sv
// rtl/rom_download_loader.sv - converts the ioctl byte download into handshaked region writes and gates core reset
module rom_download_loader #(
  parameter logic [7:0]  ROM_INDEX   = 8'd0,
  parameter logic [16:0] TOTAL_BYTES = 17'h1_8000,
  parameter logic [16:0] SND_BASE    = 17'h0_C000,
  parameter logic [16:0] GFX_BASE    = 17'h1_0000,
  parameter int          HOLD_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        rom_wr_req,
  input  logic        rom_wr_ack,
  output logic [1:0]  rom_region,
  output logic [16:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        core_reset_n,
  output logic        load_done,
  output logic        load_ok
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_REQ, S_HOLD} state_t;

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES);

  state_t      r_state;
  logic        r_dl_q;
  logic [16:0] r_count;
  logic        r_err;
  logic [15:0] r_hold_cnt;
  logic        r_wait;
  logic        r_req;
  logic [1:0]  r_region;
  logic [16:0] r_addr;
  logic [7:0]  r_data;
  logic        r_core_rst_n;
  logic        r_done;
  logic        r_ok;

  logic        w_dl_rise;
  logic        w_in_range;
  logic [16:0] w_addr;
  logic [1:0]  w_region;
  logic [16:0] w_local;
  logic        w_final_ok;

  assign w_dl_rise  = ioctl_download & ~r_dl_q;
  assign w_in_range = (ioctl_addr < {8'd0, TOTAL_BYTES});
  assign w_addr     = ioctl_addr[16:0];
  assign w_final_ok = (r_count == TOTAL_BYTES) && !r_err;

  // Base ordering guarantees none of these subtractions can wrap.
  always_comb begin
    w_region = 2'd2;
    w_local  = w_addr - GFX_BASE;
    if (w_addr < SND_BASE) begin
      w_region = 2'd0;
      w_local  = w_addr;
    end else if (w_addr < GFX_BASE) begin
      w_region = 2'd1;
      w_local  = w_addr - SND_BASE;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_dl_q       <= 1'b0;
      r_count      <= '0;
      r_err        <= 1'b0;
      r_hold_cnt   <= '0;
      r_wait       <= 1'b0;
      r_req        <= 1'b0;
      r_region     <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_core_rst_n <= 1'b0;
      r_done       <= 1'b0;
      r_ok         <= 1'b0;
    end else begin
      r_dl_q <= ioctl_download;
      case (r_state)
        S_IDLE: begin
          if (w_dl_rise && (ioctl_index == ROM_INDEX)) begin
            r_state      <= S_ARMED;
            r_count      <= '0;
            r_err        <= 1'b0;
            r_done       <= 1'b0;
            r_ok         <= 1'b0;
            r_core_rst_n <= 1'b0;
          end
        end
        S_ARMED: begin
          if (!ioctl_download) begin
            r_state    <= S_HOLD;
            r_hold_cnt <= '0;
          end else if (ioctl_wr) begin
            if (w_in_range) begin
              r_region <= w_region;
              r_addr   <= w_local;
              r_data   <= ioctl_dout;
              r_req    <= 1'b1;
              r_wait   <= 1'b1;
              r_state  <= S_REQ;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (ioctl_wr) begin
            r_err <= 1'b1;
          end
          if (rom_wr_ack) begin
            r_req  <= 1'b0;
            r_wait <= 1'b0;
            if (r_count == TOTAL_BYTES) begin
              r_err <= 1'b1;
            end else begin
              r_count <= r_count + 17'd1;
            end
            if (ioctl_download) begin
              r_state <= S_ARMED;
            end else begin
              r_state    <= S_HOLD;
              r_hold_cnt <= '0;
            end
          end
        end
        S_HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_state      <= S_IDLE;
            r_done       <= 1'b1;
            r_ok         <= w_final_ok;
            r_core_rst_n <= w_final_ok;
          end else begin
            r_hold_cnt <= r_hold_cnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ioctl_wait   = r_wait;
  assign rom_wr_req   = r_req;
  assign rom_region   = r_region;
  assign rom_addr     = r_addr;
  assign rom_data     = r_data;
  assign core_reset_n = r_core_rst_n;
  assign load_done    = r_done;
  assign load_ok      = r_ok;

endmodule

// File: tb/tb_rom_download_loader.sv
// tb/tb_rom_download_loader.sv - directed/randomized bench for rom_download_loader with a ROM port responder
module tb_rom_download_loader;

  localparam int TOTAL = 384;
  localparam int SND   = 192;
  localparam int GFX   = 256;
  localparam int HOLD  = 16;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        rom_wr_req;
  logic        rom_wr_ack;
  logic [1:0]  rom_region;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data;
  logic        core_reset_n;
  logic        load_done;
  logic        load_ok;

  rom_download_loader #(
    .ROM_INDEX(8'd0), .TOTAL_BYTES(17'(TOTAL)), .SND_BASE(17'(SND)),
    .GFX_BASE(17'(GFX)), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .rom_wr_req(rom_wr_req),
    .rom_wr_ack(rom_wr_ack), .rom_region(rom_region), .rom_addr(rom_addr),
    .rom_data(rom_data), .core_reset_n(core_reset_n), .load_done(load_done),
    .load_ok(load_ok)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  r;
    logic [16:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t        wlog[$];
  int         sent[$];
  logic [7:0] img [0:TOTAL-1];
  int         n_asserts = 0;
  int         n_fail = 0;
  int         ack_mode = 0;
  int         stab_err = 0;
  int         wait_err = 0;
  int         last_ack_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_region(input int a);
    return (a < SND) ? 2'd0 : (a < GFX) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [16:0] exp_local(input int a);
    return (a < SND) ? 17'(a) : (a < GFX) ? 17'(a - SND) : 17'(a - GFX);
  endfunction

  // ROM port model: acks each request after a programmable number of wait cycles.
  initial begin
    int wcnt;
    int cur_delay;
    bit in_req;
    wr_t held;
    rom_wr_ack = 1'b0;
    in_req = 1'b0;
    wcnt = 0;
    cur_delay = 0;
    forever begin
      @(posedge clk_sys); #1;
      rom_wr_ack = 1'b0;
      if (rom_wr_req === 1'b1) begin
        if (!in_req) begin
          in_req = 1'b1;
          wcnt = 0;
          cur_delay = (ack_mode < 0) ? int'($urandom_range(0, 3)) : ack_mode;
          held = '{rom_region, rom_addr, rom_data};
        end else if (held.r !== rom_region || held.a !== rom_addr || held.d !== rom_data) begin
          stab_err++;
        end
        if (ioctl_wait !== 1'b1) wait_err++;
        if (wcnt == cur_delay) begin
          rom_wr_ack = 1'b1;
          wlog.push_back(held);
          last_ack_cyc = cyc;
          in_req = 1'b0;
        end else begin
          wcnt++;
        end
      end else begin
        in_req = 1'b0;
        if (ioctl_wait !== 1'b0) wait_err++;
      end
    end
  end

  task automatic strobe(input int a, input logic [7:0] d);
    ioctl_wr = 1'b1;
    ioctl_addr = 25'(a);
    ioctl_dout = d;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 50 && ioctl_wait; k++) begin
      @(posedge clk_sys); #1;
    end
    if (ioctl_wait) chk("ready_timeout", ioctl_wait, 1'b0);
  endtask

  task automatic run_dl(input string nm, input int nbytes, input int mode, input bit drop_in_req,
                        input int oor_at, input int viol_at);
    bit exp_ok;
    int ref_cyc;
    int mism;
    exp_ok = (nbytes == TOTAL) && (oor_at < 0) && (viol_at < 0);
    for (int i = 0; i < TOTAL; i++) img[i] = 8'($urandom);
    wlog.delete();
    sent.delete();
    stab_err = 0;
    wait_err = 0;
    ack_mode = mode;
    ioctl_index = 8'd0;
    @(posedge clk_sys); #1;
    ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    chk({nm, "_start_done"}, load_done, 1'b0);
    chk({nm, "_start_core"}, core_reset_n, 1'b0);
    for (int i = 0; i < nbytes; i++) begin
      if (i == oor_at) begin
        strobe(TOTAL, 8'hA5);
        chk({nm, "_oor_req"}, rom_wr_req, 1'b0);
        chk({nm, "_oor_wait"}, ioctl_wait, 1'b0);
      end
      strobe(i, img[i]);
      sent.push_back(i);
      if (i == viol_at) begin
        ioctl_wr = 1'b1;
        ioctl_addr = 25'd0;
        ioctl_dout = ~img[0];
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0;
      end
      if (drop_in_req && i == nbytes - 1) ioctl_download = 1'b0;
      wait_ready();
    end
    ref_cyc = cyc;
    if (!drop_in_req) ioctl_download = 1'b0;
    else ref_cyc = last_ack_cyc;
    for (int k = 0; k < 100 && !load_done; k++) begin
      @(posedge clk_sys); #1;
    end
    chk({nm, "_done_timing"}, 32'(cyc - ref_cyc), 32'(HOLD + 2));
    chk({nm, "_load_ok"}, load_ok, exp_ok);
    chk({nm, "_core_rst"}, core_reset_n, exp_ok);
    chk({nm, "_wr_count"}, wlog.size(), sent.size());
    mism = 0;
    for (int i = 0; i < wlog.size() && i < sent.size(); i++) begin
      if (wlog[i].r !== exp_region(sent[i]) || wlog[i].a !== exp_local(sent[i]) ||
          wlog[i].d !== img[sent[i]]) mism++;
    end
    chk({nm, "_wr_content"}, mism, 0);
    chk({nm, "_stable"}, stab_err, 0);
    chk({nm, "_wait_track"}, wait_err, 0);
    repeat (20) @(posedge clk_sys);
    #1;
    chk({nm, "_core_rst_later"}, core_reset_n, exp_ok);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_req;
    int nw;
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index = 8'd0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_wait", ioctl_wait, 1'b0);
    chk("rst_req", rom_wr_req, 1'b0);
    chk("rst_core", core_reset_n, 1'b0);
    chk("rst_done", load_done, 1'b0);
    chk("rst_ok", load_ok, 1'b0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;

    run_dl("full", TOTAL, 0, 1'b0, -1, -1);
    chk("bnd_r0", {15'd0, wlog[SND-1].r, wlog[SND-1].a}, {15'd0, 2'd0, 17'(SND - 1)});
    chk("bnd_r1", {15'd0, wlog[SND].r, wlog[SND].a}, {15'd0, 2'd1, 17'd0});
    chk("bnd_r2", {15'd0, wlog[GFX].r, wlog[GFX].a}, {15'd0, 2'd2, 17'd0});

    nw = wlog.size();
    saw_req = 1'b0;
    ioctl_index = 8'd1;
    @(posedge clk_sys); #1;
    ioctl_download = 1'b1;
    for (int i = 0; i < 4; i++) begin
      strobe(i, 8'(i + 1));
      repeat (3) begin
        if (rom_wr_req || ioctl_wait) saw_req = 1'b1;
        @(posedge clk_sys); #1;
      end
    end
    chk("badidx_req", saw_req, 1'b0);
    chk("badidx_writes", wlog.size(), nw);
    chk("badidx_core", core_reset_n, 1'b1);
    chk("badidx_done", load_done, 1'b1);
    ioctl_download = 1'b0;
    ioctl_index = 8'd0;
    repeat (2) @(posedge clk_sys);
    #1;

    run_dl("bp", TOTAL, 5, 1'b1, -1, -1);
    run_dl("rnd", TOTAL, -1, 1'b1, -1, -1);
    run_dl("short", TOTAL - 1, -1, 1'b0, -1, -1);
    run_dl("oor", TOTAL, -1, 1'b0, 100, -1);
    run_dl("viol", TOTAL, 5, 1'b0, -1, 10);

    ack_mode = 5;
    @(posedge clk_sys); #1;
    ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    strobe(GFX + 5, 8'h5A);
    chk("mid_req", rom_wr_req, 1'b1);
    chk("mid_addr", {13'd0, rom_region, rom_addr}, {13'd0, 2'd2, 17'd5});
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_req", rom_wr_req, 1'b0);
    chk("arst_wait", ioctl_wait, 1'b0);
    chk("arst_region", rom_region, 2'd0);
    chk("arst_addr", rom_addr, 17'd0);
    chk("arst_data", rom_data, 8'd0);
    chk("arst_flags", {core_reset_n, load_done, load_ok}, 3'b000);
    ioctl_download = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    @(posedge clk_sys); #1;
    chk("arst_core_after", core_reset_n, 1'b0);
    run_dl("after_rst", TOTAL, -1, 1'b0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
